dac_channel_scheduler: RTL and testbench

Multi-requester scheduler for the PMOD DA4 (8-channel, 12-bit) SPI DAC path. Collects per-channel write requests from up to eight producers, coalesces each channel to its latest value, and hands complete 32-bit DAC command frames one at a time to the downstream SPI frame shifter. After reset it first issues the DAC internal-reference enable frame. Sits between application logic and the SPI shifter, in the `clk100mhz` domain.

---
 rtl/dac_channel_scheduler.sv | 128 ++++++++++++
 tb/tb_dac_channel_scheduler.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dac_channel_scheduler.sv
// Round-robin scheduler that coalesces per-channel DAC writes and hands one
// 32-bit PMOD DA4 command frame at a time to the SPI frame shifter.
module dac_channel_scheduler #(
    parameter int unsigned NCH       = 8,
    parameter logic [31:0] INIT_WORD = 32'h08000001
) (
    input  logic              clk100mhz,
    input  logic              rst,
    input  logic              sched_en,
    input  logic [NCH-1:0]    req_valid,
    input  logic [NCH*12-1:0] req_data,
    output logic [NCH-1:0]    req_ack,
    output logic              frame_valid,
    output logic [31:0]       frame_data,
    input  logic              frame_ready,
    input  logic              frame_done,
    output logic              init_done,
    output logic              busy,
    output logic [15:0]       frames_sent
);

    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    typedef enum logic [2:0] {
        S_INIT_SEND,
        S_INIT_WAIT,
        S_IDLE,
        S_SEND,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [11:0]     value_q [NCH];
    logic [NCH-1:0]  pending_q;
    logic [NCH-1:0]  clear_mask;
    logic [CW-1:0]   last_grant_q;
    logic [CW-1:0]   grant_q;
    logic [CW-1:0]   pick_idx;
    logic            pick_found;
    logic            grant_fire;
    int              rr_idx;

    // Round-robin search: first pending channel after the last one served.
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        rr_idx     = 0;
        for (int k = 1; k <= int'(NCH); k++) begin
            rr_idx = (int'(last_grant_q) + k) % int'(NCH);
            if (!pick_found && pending_q[CW'(rr_idx)]) begin
                pick_found = 1'b1;
                pick_idx   = CW'(rr_idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_fire = 1'b0;
        unique case (state_q)
            S_INIT_SEND: if (frame_valid && frame_ready) state_d = S_INIT_WAIT;
            S_INIT_WAIT: if (frame_done) state_d = S_IDLE;
            S_IDLE: begin
                if (sched_en && pick_found) begin
                    state_d    = S_SEND;
                    grant_fire = 1'b1;
                end
            end
            S_SEND:      if (frame_valid && frame_ready) state_d = S_WAIT;
            S_WAIT:      if (frame_done) state_d = S_IDLE;
            default:     state_d = S_INIT_SEND;
        endcase
    end

    assign clear_mask = grant_fire ? (NCH'(1) << pick_idx) : '0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register sees the pre-edge value of every other register.
    always_ff @(posedge clk100mhz or negedge rst) begin
        if (!rst) begin
            state_q      <= S_INIT_SEND;
            pending_q    <= '0;
            last_grant_q <= CW'(NCH - 1);
            grant_q      <= '0;
            frame_valid  <= 1'b0;
            frame_data   <= '0;
            req_ack      <= '0;
            init_done    <= 1'b0;
            busy         <= 1'b0;
            frames_sent  <= '0;
        end else begin
            state_q     <= state_d;
            frame_valid <= (state_d == S_INIT_SEND) || (state_d == S_SEND);
            busy        <= (state_d != S_IDLE);
            req_ack     <= '0;
            // A new strobe on the granted channel re-arms it (set beats clear).
            pending_q   <= (pending_q & ~clear_mask) | req_valid;

            if (state_d == S_INIT_SEND) begin
                frame_data <= INIT_WORD;
            end else if (grant_fire) begin
                frame_data <= {8'h03, 4'(pick_idx), value_q[pick_idx], 8'h00};
                grant_q    <= pick_idx;
            end

            if (state_q == S_INIT_WAIT && frame_done) begin
                init_done <= 1'b1;
            end

            if (state_q == S_WAIT && frame_done) begin
                req_ack[grant_q] <= 1'b1;
                frames_sent      <= frames_sent + 16'd1;
                last_grant_q     <= grant_q;
            end
        end
    end

    // NOTE: value registers carry no reset; a value is only read once its
    // pending bit (which is reset) shows it was loaded.
    always_ff @(posedge clk100mhz) begin
        for (int i = 0; i < int'(NCH); i++) begin
            if (req_valid[i]) value_q[i] <= req_data[12*i +: 12];
        end
    end

endmodule

// File: tb/tb_dac_channel_scheduler.sv
// Scoreboard bench for dac_channel_scheduler: a shifter model pops expected
// frames/acks at each handshake and compares against the DUT.
module tb_dac_channel_scheduler;

    localparam int          NCH       = 8;
    localparam logic [31:0] INIT_WORD = 32'h08000001;

    logic              clk100mhz = 1'b0;
    logic              rst = 1'b0;
    logic              sched_en = 1'b1;
    logic [NCH-1:0]    req_valid = '0;
    logic [NCH*12-1:0] req_data = '0;
    logic [NCH-1:0]    req_ack;
    logic              frame_valid;
    logic [31:0]       frame_data;
    logic              frame_ready = 1'b0;
    logic              frame_done = 1'b0;
    logic              init_done;
    logic              busy;
    logic [15:0]       frames_sent;

    int                n_checks = 0;
    int                n_fail = 0;
    logic [31:0]       exp_q [$];
    int                ack_q [$];
    logic [15:0]       exp_sent = '0;

    dac_channel_scheduler #(.NCH(NCH), .INIT_WORD(INIT_WORD)) dut (
        .clk100mhz  (clk100mhz),
        .rst        (rst),
        .sched_en   (sched_en),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ack    (req_ack),
        .frame_valid(frame_valid),
        .frame_data (frame_data),
        .frame_ready(frame_ready),
        .frame_done (frame_done),
        .init_done  (init_done),
        .busy       (busy),
        .frames_sent(frames_sent)
    );

    always #5 clk100mhz = ~clk100mhz;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk100mhz);
    endtask

    function automatic logic [31:0] mk_frame(input int ch, input logic [11:0] v);
        return {8'h03, 4'(ch), v, 8'h00};
    endfunction

    task automatic strobe(input int ch, input logic [11:0] val, input bit push);
        req_valid[ch]          = 1'b1;
        req_data[12*ch +: 12]  = val;
        if (push) begin
            exp_q.push_back(mk_frame(ch, val));
            ack_q.push_back(ch);
        end
        tick();
        req_valid = '0;
    endtask

    // Shifter model: accept after rdy_dly cycles, signal done done_dly later.
    task automatic serve(input int rdy_dly, input int done_dly, input bit is_init,
                         input int mid_ch, input logic [11:0] mid_val);
        int          n;
        logic [31:0] exp_frame;
        int          exp_ch;
        n = 0;
        while (!frame_valid && n < 200) begin
            tick();
            n++;
        end
        if (!frame_valid) begin
            check("frame_valid_timeout", {31'b0, frame_valid}, 32'd1);
            return;
        end
        repeat (rdy_dly) tick();
        check("valid_held", {31'b0, frame_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            check("unexpected_frame", frame_data, 32'hxxxxxxxx);
            return;
        end
        exp_frame = exp_q.pop_front();
        check("frame_data", frame_data, exp_frame);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        check("valid_drop", {31'b0, frame_valid}, 32'd0);
        if (mid_ch >= 0) strobe(mid_ch, mid_val, 1'b1);
        repeat (done_dly) tick();
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        check("gap_after_done", {31'b0, frame_valid}, 32'd0);
        if (is_init) begin
            check("init_done", {31'b0, init_done}, 32'd1);
            check("init_no_ack", 32'(req_ack), 32'd0);
        end else begin
            exp_ch   = (ack_q.size() > 0) ? ack_q.pop_front() : 0;
            exp_sent = exp_sent + 16'd1;
            check("req_ack", 32'(req_ack), 32'(NCH'(1) << exp_ch));
        end
        check("frames_sent", 32'(frames_sent), 32'(exp_sent));
        tick();
        check("ack_one_cycle", 32'(req_ack), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        check("rst_frame_valid", {31'b0, frame_valid}, 32'd0);
        check("rst_frame_data", frame_data, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_init_done", {31'b0, init_done}, 32'd0);
        check("rst_frames_sent", 32'(frames_sent), 32'd0);
        check("rst_req_ack", 32'(req_ack), 32'd0);
        tick();
        rst = 1'b1;
        tick();
        check("init_valid_first_edge", {31'b0, frame_valid}, 32'd1);
        check("init_busy_first_edge", {31'b0, busy}, 32'd1);

        // Init frame: ready after 3 cycles, done 10 later
        exp_q.push_back(INIT_WORD);
        serve(3, 10, 1'b1, -1, 12'h000);
        check("idle_busy", {31'b0, busy}, 32'd0);

        // ch0, ch2, ch5 together; ch0 re-strobed during its WAIT
        req_valid = 8'b0010_0101;
        req_data[0 +: 12]  = 12'hABC;
        req_data[24 +: 12] = 12'h222;
        req_data[60 +: 12] = 12'h555;
        exp_q.push_back(mk_frame(0, 12'hABC)); ack_q.push_back(0);
        exp_q.push_back(mk_frame(2, 12'h222)); ack_q.push_back(2);
        exp_q.push_back(mk_frame(5, 12'h555)); ack_q.push_back(5);
        tick();
        req_valid = '0;
        serve(0, 3, 1'b0, 0, 12'h123);
        serve(1, 2, 1'b0, -1, 12'h000);
        serve(2, 1, 1'b0, -1, 12'h000);
        serve(0, 4, 1'b0, -1, 12'h000);

        // ch3 single strobe: latency to frame_valid
        strobe(3, 12'h7FF, 1'b1);
        check("lat_pending_cycle", {31'b0, frame_valid}, 32'd0);
        tick();
        check("lat_valid", {31'b0, frame_valid}, 32'd1);
        check("lat_data", frame_data, 32'h0337FF00);
        serve(0, 10, 1'b0, -1, 12'h000);

        // ch1 coalescing while scheduling is disabled
        sched_en = 1'b0;
        strobe(1, 12'h001, 1'b0);
        strobe(1, 12'h002, 1'b0);
        strobe(1, 12'h003, 1'b1);
        repeat (5) tick();
        check("disabled_no_frame", {31'b0, frame_valid}, 32'd0);
        check("disabled_idle", {31'b0, busy}, 32'd0);
        sched_en = 1'b1;
        serve(1, 4, 1'b0, -1, 12'h000);
        repeat (4) tick();
        check("coalesced_single", {31'b0, frame_valid}, 32'd0);

        // Reset during SEND of ch4
        strobe(4, 12'h456, 1'b0);
        tick();
        check("ch4_send_data", frame_data, mk_frame(4, 12'h456));
        rst = 1'b0;
        #1;
        check("midrst_valid", {31'b0, frame_valid}, 32'd0);
        check("midrst_data", frame_data, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_sent", 32'(frames_sent), 32'd0);
        exp_sent = '0;
        tick();
        tick();
        rst = 1'b1;
        exp_q.push_back(INIT_WORD);
        serve(2, 5, 1'b1, -1, 12'h000);
        repeat (10) tick();
        check("ch4_dropped", {31'b0, frame_valid}, 32'd0);

        // frames_sent wrap
        force dut.frames_sent = 16'hFFFF;
        tick();
        release dut.frames_sent;
        tick();
        check("preload_sent", 32'(frames_sent), 32'h0000FFFF);
        exp_sent = 16'hFFFF;
        strobe(6, 12'hFED, 1'b1);
        serve(0, 2, 1'b0, -1, 12'h000);

        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
